// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter_if
//  Purpose  : Bundles the two core request ports and the single-port data
//             memory port of the data-memory arbiter.
//  Ports    : req/we/lock/addr/wdata per core (to arbiter), ack/rdata per
//             core (from arbiter), mem_en/mem_we/mem_addr/mem_wdata (from
//             arbiter), mem_rdata (to arbiter), owner/busy status.
//  Modports : slave  - arbiter side
//             master - cores + memory side (testbench / top level)
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic              lock0;
   logic              lock1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              ack0;
   logic              ack1;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              owner;
   logic              busy;

   modport slave (
      input  req0, req1, we0, we1, lock0, lock1,
      input  addr0, addr1, wdata0, wdata1,
      output ack0, ack1, rdata0, rdata1,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output owner, busy
   );

   modport master (
      output req0, req1, we0, we1, lock0, lock1,
      output addr0, addr1, wdata0, wdata1,
      input  ack0, ack1, rdata0, rdata1,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  owner, busy
   );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Round-robin arbiter sharing one single-port, synchronous-read
//             data memory between two CPU cores, with a bounded lock facility
//             for read-modify-write sequences.
//  Ports    : clk   - rising-edge clock
//             reset - synchronous, active-low
//             bus   - dmem_arbiter_if.slave (core ports, memory port, status)
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);

   localparam int                c_cnt_w    = $clog2(LOCK_MAX + 1);
   localparam logic [c_cnt_w-1:0] c_lock_max = c_cnt_w'(LOCK_MAX);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_prio;
   logic                r_hold;
   logic [c_cnt_w-1:0]  r_lock_cnt;
   logic                r_owner;
   logic                r_we;
   logic                r_lock;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata0;
   logic [DATA_W-1:0]   r_rdata1;

   state_t              w_state_next;
   logic                w_prio_next;
   logic                w_hold_next;
   logic [c_cnt_w-1:0]  w_cnt_next;
   logic [c_cnt_w-1:0]  w_cnt_inc;
   logic                w_elig0;
   logic                w_elig1;
   logic                w_arb;
   logic                w_grant;
   logic                w_winner;
   logic                w_rd_resp;

   // ------------------------------------------------------------------
   // Next-state, lock bookkeeping and arbitration
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_prio_next  = r_prio;
      w_hold_next  = r_hold;
      w_cnt_next   = r_lock_cnt;
      w_elig0      = 1'b0;
      w_elig1      = 1'b0;
      w_arb        = 1'b0;
      w_grant      = 1'b0;
      w_winner     = r_owner;
      w_cnt_inc    = (r_lock_cnt == c_lock_max) ? r_lock_cnt : r_lock_cnt + 1'b1;

      case (r_state)
         S_IDLE: begin
            w_arb = 1'b1;
            if (r_hold) begin
               // Hold active: only the owner may come back in.
               w_elig0 = bus.req0 & ~r_owner;
               w_elig1 = bus.req1 &  r_owner;
            end else begin
               w_elig0 = bus.req0;
               w_elig1 = bus.req1;
            end
         end
         S_ACCESS: begin
            w_state_next = S_RESP;
         end
         S_RESP: begin
            w_arb = 1'b1;
            // Decide whether the hold survives this completed access.
            if (r_lock && (w_cnt_inc < c_lock_max)) begin
               w_hold_next = 1'b1;
               w_cnt_next  = w_cnt_inc;
            end else begin
               w_hold_next = 1'b0;
               w_cnt_next  = '0;
               w_prio_next = ~r_owner;
            end
            // Owner is re-eligible only under a hold; otherwise the
            // acked core is excluded so the other core gets its turn.
            if (w_hold_next) begin
               w_elig0 = bus.req0 & ~r_owner;
               w_elig1 = bus.req1 &  r_owner;
            end else begin
               w_elig0 = bus.req0 &  r_owner;
               w_elig1 = bus.req1 & ~r_owner;
            end
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      if (w_arb && (w_elig0 || w_elig1)) begin
         w_grant      = 1'b1;
         w_winner     = (w_elig0 && w_elig1) ? r_prio : w_elig1;
         w_state_next = S_ACCESS;
      end
   end

   // ------------------------------------------------------------------
   // State and latch registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_prio     <= 1'b0;
         r_hold     <= 1'b0;
         r_lock_cnt <= '0;
         r_owner    <= 1'b0;
         r_we       <= 1'b0;
         r_lock     <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata0   <= '0;
         r_rdata1   <= '0;
      end else begin
         r_state    <= w_state_next;
         r_prio     <= w_prio_next;
         r_hold     <= w_hold_next;
         r_lock_cnt <= w_cnt_next;
         if (w_grant) begin
            r_owner <= w_winner;
            r_we    <= w_winner ? bus.we1    : bus.we0;
            r_lock  <= w_winner ? bus.lock1  : bus.lock0;
            r_addr  <= w_winner ? bus.addr1  : bus.addr0;
            r_wdata <= w_winner ? bus.wdata1 : bus.wdata0;
         end
         if (w_rd_resp) begin
            if (r_owner) begin
               r_rdata1 <= bus.mem_rdata;
            end else begin
               r_rdata0 <= bus.mem_rdata;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs: all memory-side signals come straight from registers
   // ------------------------------------------------------------------
   assign w_rd_resp     = (r_state == S_RESP) & ~r_we;

   assign bus.mem_en    = (r_state == S_ACCESS);
   assign bus.mem_we    = (r_state == S_ACCESS) & r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;

   assign bus.ack0      = (r_state == S_RESP) & ~r_owner;
   assign bus.ack1      = (r_state == S_RESP) &  r_owner;

   // Read data is presented in the ack cycle straight from the memory and
   // captured so it holds until the next read ack to the same core.
   assign bus.rdata0    = (w_rd_resp & ~r_owner) ? bus.mem_rdata : r_rdata0;
   assign bus.rdata1    = (w_rd_resp &  r_owner) ? bus.mem_rdata : r_rdata1;

   assign bus.owner     = r_owner;
   assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed self-checking bench for dmem_arbiter with a small
//             synchronous-read memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dmem_arbiter #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .LOCK_MAX (4)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port synchronous-read memory, preloaded while reset is low.
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (!reset) begin
         mem[8'h10] <= 32'hDEAD_BEEF;
         mem[8'h20] <= 32'h0000_0000;
      end else if (bus.mem_en) begin
         if (bus.mem_we) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
         end
         bus.mem_rdata <= mem[bus.mem_addr[7:0]];
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      reset      = 1'b0;
      bus.req0   = 1'b0;  bus.req1   = 1'b0;
      bus.we0    = 1'b0;  bus.we1    = 1'b0;
      bus.lock0  = 1'b0;  bus.lock1  = 1'b0;
      bus.addr0  = '0;    bus.addr1  = '0;
      bus.wdata0 = '0;    bus.wdata1 = '0;
      repeat (3) tick();

      // ---------------- reset values ----------------
      check("rst_busy",   {31'd0, bus.busy},   32'd0);
      check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
      check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("rst_addr",   bus.mem_addr,        32'd0);
      check("rst_wdata",  bus.mem_wdata,       32'd0);
      check("rst_ack",    {30'd0, bus.ack1, bus.ack0}, 32'd0);
      check("rst_rdata0", bus.rdata0,          32'd0);
      check("rst_owner",  {31'd0, bus.owner},  32'd0);
      reset = 1'b1;
      tick();

      // ---------------- single read ----------------
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
      tick();
      check("rd_mem_en",   {31'd0, bus.mem_en}, 32'd1);
      check("rd_mem_we",   {31'd0, bus.mem_we}, 32'd0);
      check("rd_mem_addr", bus.mem_addr,        32'h10);
      check("rd_ack_early",{30'd0, bus.ack1, bus.ack0}, 32'd0);
      tick();
      check("rd_ack",   {30'd0, bus.ack1, bus.ack0}, 32'b01);
      check("rd_rdata", bus.rdata0, 32'hDEAD_BEEF);
      bus.req0 = 1'b0;
      tick();
      check("rd_idle",  {30'd0, bus.busy, bus.ack0}, 32'd0);
      check("rd_hold",  bus.rdata0, 32'hDEAD_BEEF);

      // ---------------- write then read ----------------
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h20; bus.wdata1 = 32'h1234_5678;
      tick();
      check("wr_mem_we",  {31'd0, bus.mem_we}, 32'd1);
      check("wr_wdata",   bus.mem_wdata,       32'h1234_5678);
      check("wr_owner",   {31'd0, bus.owner},  32'd1);
      tick();
      check("wr_ack",     {30'd0, bus.ack1, bus.ack0}, 32'b10);
      check("wr_rdata1",  bus.rdata1, 32'd0);
      bus.req1 = 1'b0; bus.we1 = 1'b0;
      tick();
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h20;
      tick();
      tick();
      check("wr_rd_ack",  {30'd0, bus.ack1, bus.ack0}, 32'b01);
      check("wr_rd_data", bus.rdata0, 32'h1234_5678);
      bus.req0 = 1'b0;
      tick();
      check("wr_rdata1_keep", bus.rdata1, 32'd0);

      // ---------------- contention from reset ----------------
      reset = 1'b0;
      tick();
      reset = 1'b1;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h10;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("ct_owner",  {31'd0, bus.owner}, 32'(i % 2));
         check("ct_mem_en", {31'd0, bus.mem_en}, 32'd1);
         tick();
         check("ct_ack", {30'd0, bus.ack1, bus.ack0}, (i % 2 == 0) ? 32'b01 : 32'b10);
      end
      check("ct_rdata1", bus.rdata1, 32'hDEAD_BEEF);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      tick();
      check("ct_idle", {31'd0, bus.busy}, 32'd0);

      // ---------------- lock hold: 3 locked + 1 unlocked ----------------
      bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.req1 = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("lk_owner", {31'd0, bus.owner}, 32'd0);
         tick();
         check("lk_ack", {30'd0, bus.ack1, bus.ack0}, 32'b01);
         if (k == 3) bus.lock0 = 1'b0;
         if (k == 4) bus.req0  = 1'b0;
      end
      tick();
      check("lk_grant1", {31'd0, bus.owner}, 32'd1);
      tick();
      check("lk_ack1", {30'd0, bus.ack1, bus.ack0}, 32'b10);
      bus.req1 = 1'b0;
      tick();

      // ---------------- forced release ----------------
      bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.req1 = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("fr_owner", {31'd0, bus.owner}, 32'd0);
         tick();
         check("fr_ack", {30'd0, bus.ack1, bus.ack0}, 32'b01);
      end
      tick();
      check("fr_grant1", {31'd0, bus.owner}, 32'd1);
      tick();
      check("fr_ack1", {30'd0, bus.ack1, bus.ack0}, 32'b10);
      bus.req0 = 1'b0; bus.lock0 = 1'b0; bus.req1 = 1'b0;
      tick();
      check("fr_idle", {31'd0, bus.busy}, 32'd0);

      // ---------------- reset mid-access ----------------
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h30; bus.wdata0 = 32'hCAFE_F00D;
      tick();
      check("ra_mem_we", {31'd0, bus.mem_we}, 32'd1);
      reset = 1'b0;
      tick();
      check("ra_ack",    {30'd0, bus.ack1, bus.ack0}, 32'd0);
      check("ra_mem_we0",{31'd0, bus.mem_we}, 32'd0);
      check("ra_mem_en0",{31'd0, bus.mem_en}, 32'd0);
      check("ra_busy",   {31'd0, bus.busy},   32'd0);
      check("ra_addr",   bus.mem_addr,        32'd0);
      check("ra_wdata",  bus.mem_wdata,       32'd0);
      check("ra_rdata0", bus.rdata0,          32'd0);
      reset = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
      tick();
      check("ra_new_en", {31'd0, bus.mem_en}, 32'd1);
      tick();
      check("ra_new_ack",  {30'd0, bus.ack1, bus.ack0}, 32'b01);
      check("ra_new_data", bus.rdata0, 32'hDEAD_BEEF);
      bus.req0 = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
